// File: rtl/gf128_clmul_seq_if.sv
// Handshake bundle for gf128_clmul_seq.
//   Operand side : valid_i, ready_o, a_i[127:0], b_i[127:0]
//   Result side  : valid_o, ready_i, data_o[255:0]
//   flush_i      : synchronous abort, present only with GF128_CLMUL_FLUSH_EN
// The slave modport is the multiplier; the master modport is whoever drives
// operands and consumes products.
interface gf128_clmul_seq_if;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] a_i;
  logic [127:0] b_i;
  logic         valid_o;
  logic         ready_i;
  logic [255:0] data_o;
`ifdef GF128_CLMUL_FLUSH_EN
  logic         flush_i;
`endif

  modport slave (
    input  valid_i,
    input  a_i,
    input  b_i,
    input  ready_i,
`ifdef GF128_CLMUL_FLUSH_EN
    input  flush_i,
`endif
    output ready_o,
    output valid_o,
    output data_o
  );

  modport master (
    output valid_i,
    output a_i,
    output b_i,
    output ready_i,
`ifdef GF128_CLMUL_FLUSH_EN
    output flush_i,
`endif
    input  ready_o,
    input  valid_o,
    input  data_o
  );
endinterface

// File: rtl/gf128_clmul_seq.sv
// Digit-serial carry-less multiplier: 128b x 128b -> 256b unreduced GF(2)[x]
// product, bit i = coefficient of x^i. Consumes DIGIT_W bits of B per cycle,
// MSB digit first, so an operation takes N = 128/DIGIT_W compute cycles with
// latency independent of the operand values.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     gf128_clmul_seq_if.slave (operand handshake, result handshake,
//           optional flush_i)
// Build option: define GF128_CLMUL_FLUSH_EN to add the synchronous flush_i
// abort, which beats every other event in the same cycle.
module gf128_clmul_seq #(
  parameter int unsigned DIGIT_W = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  gf128_clmul_seq_if.slave    bus
);

  localparam int unsigned N     = 128 / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8 ||
        DIGIT_W == 16 || DIGIT_W == 32)) begin : g_bad_digit_w
    $error("gf128_clmul_seq: DIGIT_W must be one of 1,2,4,8,16,32");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [127:0]       r_a;
  logic [127:0]       r_b;
  logic [255:0]       r_acc;
  logic [255:0]       r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] w_digit;
  logic [255:0]       w_pp;
  logic [255:0]       w_acc_next;
  logic               w_last;
  logic               w_flush;

`ifdef GF128_CLMUL_FLUSH_EN
  assign w_flush = bus.flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // r_b shifts left each CALC cycle, so its top digit is always the current
  // MSB-first digit of the captured B.
  assign w_digit = r_b[127 -: DIGIT_W];
  assign w_last  = (r_cnt == CNT_W'(N - 1));

  always_comb begin
    w_pp = '0;
    for (int unsigned j = 0; j < DIGIT_W; j++) begin
      if (w_digit[j]) begin
        w_pp = w_pp ^ ({128'd0, r_a} << j);
      end
    end
    w_acc_next = (r_acc << DIGIT_W) ^ w_pp;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (bus.valid_i) w_state_next = StCalc;
      StCalc:  if (w_last)      w_state_next = StDone;
      StDone:  if (bus.ready_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (w_flush) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else if (w_flush) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.valid_i) begin
            r_a   <= bus.a_i;
            r_b   <= bus.b_i;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        StCalc: begin
          r_acc <= w_acc_next;
          r_b   <= r_b << DIGIT_W;
          r_cnt <= r_cnt + CNT_W'(1);
          // Result register is separate so data_o survives the next capture.
          if (w_last) begin
            r_data <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (r_state == StIdle);
  assign bus.valid_o = (r_state == StDone);
  assign bus.data_o  = r_data;

endmodule

// File: tb/tb_gf128_clmul_seq.sv
// Self-checking bench for gf128_clmul_seq: directed corner cases plus
// randomized operations against a bit-level carry-less product model.
module tb_gf128_clmul_seq;

  localparam int unsigned DIGIT_W = 8;
  localparam int unsigned N       = 128 / DIGIT_W;
  localparam int unsigned NRAND   = 400;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  gf128_clmul_seq_if bus ();

  gf128_clmul_seq #(
    .DIGIT_W(DIGIT_W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: product coefficient k is the XOR of a[i]&b[j] over i+j==k.
  function automatic logic [255:0] clmul_ref(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      for (int j = 0; j < 128; j++) begin
        if (a[i] && b[j]) r[i+j] = ~r[i+j];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands while idle; returns after the capture edge.
  task automatic send(input logic [127:0] a, input logic [127:0] b);
    int guard;
    guard = 0;
    bus.valid_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    while (!bus.ready_o && guard < 200) begin
      tick();
      guard++;
    end
    check("send_ready", {255'd0, bus.ready_o}, 256'd1);
    tick();
    bus.valid_i = 1'b0;
  endtask

  // Counts edges from capture to valid_o; returns -1 on timeout.
  task automatic wait_valid(input bit scramble, output int cycles);
    cycles = 0;
    while (!bus.valid_o && cycles < 400) begin
      if (scramble) begin
        bus.a_i     = rand128();
        bus.b_i     = rand128();
        bus.valid_i = 1'($urandom_range(0, 1));
      end
      tick();
      cycles++;
    end
    bus.valid_i = 1'b0;
    if (!bus.valid_o) cycles = -1;
  endtask

  task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                        input int stall, input bit scramble);
    int           cyc;
    logic [255:0] exp;
    exp = clmul_ref(a, b);
    send(a, b);
    wait_valid(scramble, cyc);
    check({tag, "_latency"}, 256'(cyc), 256'(N));
    check({tag, "_data"}, bus.data_o, exp);
    for (int s = 0; s < stall; s++) begin
      bus.valid_i = 1'b1;
      bus.a_i     = rand128();
      tick();
      check({tag, "_stall_valid"}, {255'd0, bus.valid_o}, 256'd1);
      check({tag, "_stall_ready"}, {255'd0, bus.ready_o}, 256'd0);
      check({tag, "_stall_data"}, bus.data_o, exp);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check({tag, "_post_valid"}, {255'd0, bus.valid_o}, 256'd0);
    check({tag, "_post_ready"}, {255'd0, bus.ready_o}, 256'd1);
    check({tag, "_post_data"}, bus.data_o, exp);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
`ifdef GF128_CLMUL_FLUSH_EN
    bus.flush_i = 1'b0;
`endif
    rst_n = 1'b0;
    #12;
    check("reset_valid", {255'd0, bus.valid_o}, 256'd0);
    check("reset_ready", {255'd0, bus.ready_o}, 256'd1);
    check("reset_data", bus.data_o, 256'd0);
    rst_n = 1'b1;
    tick();

    // Directed corners
    run_op("one", 128'd1, 128'd1, 0, 1'b0);
    check("one_exact", bus.data_o, 256'h1);
    run_op("top", {1'b1, 127'd0}, {1'b1, 127'd0}, 0, 1'b0);
    check("top_exact", bus.data_o, {2'b01, 254'd0});
    run_op("ones3", {128{1'b1}}, 128'd3, 0, 1'b0);
    check("ones3_exact", bus.data_o, {127'd0, 1'b1, 127'd0, 1'b1});
    run_op("zero", 128'd0, rand128(), 0, 1'b0);
    run_op("stall", rand128(), rand128(), 5, 1'b0);
    run_op("after_stall", rand128(), rand128(), 0, 1'b0);

    // Reset during CALC cycle 7
    send(rand128(), rand128());
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {255'd0, bus.valid_o}, 256'd0);
    check("rst_mid_ready", {255'd0, bus.ready_o}, 256'd1);
    check("rst_mid_data", bus.data_o, 256'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_rst", rand128(), rand128(), 0, 1'b0);

`ifdef GF128_CLMUL_FLUSH_EN
    begin
      int seen;
      send(rand128(), rand128());
      for (int i = 0; i < 5; i++) tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      check("flush_calc_ready", {255'd0, bus.ready_o}, 256'd1);
      check("flush_calc_data", bus.data_o, 256'd0);
      seen = 0;
      for (int i = 0; i < N + 4; i++) begin
        tick();
        if (bus.valid_o) seen = 1;
      end
      check("flush_calc_novalid", 256'(seen), 256'd0);
      send(rand128() | 128'd1, 128'd1);
      wait_valid(1'b0, seen);
      check("flush_done_reached", {255'd0, bus.valid_o}, 256'd1);
      bus.ready_i = 1'b1;
      bus.flush_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      bus.flush_i = 1'b0;
      check("flush_done_valid", {255'd0, bus.valid_o}, 256'd0);
      check("flush_done_data", bus.data_o, 256'd0);
      check("flush_done_ready", {255'd0, bus.ready_o}, 256'd1);
    end
`endif

    // Randomized operations with idle gaps, busy-time noise and output stalls
    for (int n = 0; n < NRAND; n++) begin
      int           gap;
      logic [127:0] a;
      logic [127:0] b;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      a = rand128();
      b = rand128();
      case ($urandom_range(0, 7))
        0: a = {96'd0, a[31:0]};
        1: b = {b[127:120], 120'd0};
        default: ;
      endcase
      run_op("rand", a, b, $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench cannot hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
